// File: rtl/fifo_cfg_pkg.sv
// Shared constants and types for the configurable-threshold FIFO.
// Error-bit indices and default geometry live here so every file agrees on them.
package fifo_cfg_pkg;

  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_ADDR_WIDTH = 2;

  localparam int ERR_W   = 2;
  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

  typedef logic [ERR_W-1:0] err_t;

endpackage

// File: rtl/fifo_cfg_if.sv
// Bus bundle between the FIFO and its user.
// The producer/consumer side drives through the master modport; the FIFO uses slave.
interface fifo_cfg_if
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  localparam int CW = ADDR_WIDTH + 1;

  // push/pop are requests taken only when accepted at a rising edge; Data_Valid is a
  // one-cycle pulse qualifying Fifo_Data_out; Pausa is advisory backpressure upstream.
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] Fifo_Data_in;
  logic [CW-1:0]         thr_ae;
  logic [CW-1:0]         thr_af;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] Fifo_Data_out;
  logic                  Data_Valid;
  logic [CW-1:0]         count;
  logic                  Fifo_Empty;
  logic                  Fifo_Full;
  logic                  Almost_Empty;
  logic                  Almost_Full;
  logic                  Pausa;
  err_t                  Error_Fifo;

  modport master (
    output push, pop, Fifo_Data_in, thr_ae, thr_af, err_clr,
    input  Fifo_Data_out, Data_Valid, count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );

  modport slave (
    input  push, pop, Fifo_Data_in, thr_ae, thr_af, err_clr,
    output Fifo_Data_out, Data_Valid, count, Fifo_Empty, Fifo_Full,
           Almost_Empty, Almost_Full, Pausa, Error_Fifo
  );

endinterface

// File: rtl/fifo_cfg_dual_port_memory.sv
// Storage array with one synchronous write port and one synchronous read port.
// A read and write to the same address in one cycle returns the old word.
module dual_port_memory #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 2,
  parameter int MEM_SIZE   = 4
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_cfg.sv
// Synchronous FIFO with reset-captured almost-empty/almost-full thresholds,
// hysteretic backpressure (Pausa) and sticky overflow/underflow bits.
module fifo_cfg
  import fifo_cfg_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic       clk,
  input  logic       reset_L,
  fifo_cfg_if.slave  bus
);

  localparam int            CW      = ADDR_WIDTH + 1;
  localparam int            DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         thr_ae_q, thr_ae_d;
  logic [CW-1:0]         thr_af_q, thr_af_d;
  logic                  valid_q;
  logic                  pausa_q, pausa_d;
  err_t                  err_q, err_d;
  logic                  push_acc, pop_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    pop_acc  = reset_L && bus.pop && (count_q != '0);
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    push_acc = reset_L && bus.push && ((count_q != DEPTH_C) || pop_acc);

    wr_ptr_d = push_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = pop_acc  ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    err_d = bus.err_clr ? '0 : err_q;
    if (bus.push && !push_acc) err_d[ERR_OVF] = 1'b1;
    if (bus.pop  && !pop_acc)  err_d[ERR_UNF] = 1'b1;

    pausa_d = pausa_q;
    if (count_d >= thr_af_q) begin
      pausa_d = 1'b1;
    end else if (count_d <= thr_ae_q) begin
      pausa_d = 1'b0;
    end

    // Clamp so that thr_ae < thr_af <= DEPTH whenever thr_af is non-zero.
    thr_af_d = (bus.thr_af > DEPTH_C) ? DEPTH_C : bus.thr_af;
    thr_ae_d = '0;
    if (thr_af_d != '0) begin
      thr_ae_d = (bus.thr_ae > thr_af_d - CW'(1)) ? thr_af_d - CW'(1) : bus.thr_ae;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      pausa_q  <= 1'b0;
      err_q    <= '0;
      thr_ae_q <= thr_ae_d;
      thr_af_q <= thr_af_d;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_acc;
      pausa_q  <= pausa_d;
      err_q    <= err_d;
    end
  end

  dual_port_memory #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_ni    (reset_L),
    .wr_en_i   (push_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (bus.Fifo_Data_in),
    .rd_en_i   (pop_acc),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  assign bus.Fifo_Data_out = rd_data;
  assign bus.Data_Valid    = valid_q;
  assign bus.count         = count_q;
  assign bus.Pausa         = pausa_q;
  assign bus.Error_Fifo    = err_q;
  assign bus.Fifo_Empty    = (count_q == '0);
  assign bus.Fifo_Full     = (count_q == DEPTH_C);
  assign bus.Almost_Empty  = (count_q != '0) && (count_q <= thr_ae_q);
  assign bus.Almost_Full   = (count_q >= thr_af_q) && (count_q != DEPTH_C);

endmodule
